disable_responder: RTL

- Cancellable countdown job engine: the responding end of a block-disable protocol.
- A controller starts a job of N steps; an independent agent may kill the job at any time with disable_req.
- The engine acknowledges every disable request with a one-cycle disable_ack and reports whether a live job was killed.
- Used as the hardware counterpart of named-block disable behaviour: one initial delay cycle, work steps, then completion.

---
 rtl/disable_responder.sv | 101 ++++++++++
 1 files changed

// File: rtl/disable_responder.sv
// disable_responder: cancellable countdown job engine that answers a
// block-disable protocol. A job runs one delay cycle, N work steps and a
// one-cycle completion. Any disable request is acknowledged with a single
// ABORT cycle. The sticky aborted flag records whether a live job was killed.
module disable_responder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] length,
  input  logic             disable_req,
  output logic             busy,
  output logic             step,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             disable_ack,
  output logic             aborted
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             aborted_q, aborted_d;

  // State, count and sticky abort flag registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state logic: disable has priority over start and over work steps
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    aborted_d = aborted_q;
    unique case (state_q)
      IDLE: begin
        if (disable_req) begin
          // An idle disable is still acknowledged but kills nothing.
          state_d = ABORT;
        end else if (start) begin
          count_d   = length;
          aborted_d = 1'b0;
          state_d   = (length == '0) ? DONE : DELAY;
        end
      end
      DELAY: begin
        if (disable_req) begin
          state_d   = ABORT;
          aborted_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (disable_req) begin
          state_d   = ABORT;
          aborted_d = 1'b1;
        end else begin
          // The zero guard keeps count from wrapping if RUN is ever
          // entered with an empty count.
          if (count_q != '0) begin
            count_d = count_q - 1'b1;
          end
          if (count_q <= CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode from registered state only
  always_comb begin
    busy        = (state_q == DELAY) || (state_q == RUN) || (state_q == DONE);
    step        = (state_q == RUN);
    done        = (state_q == DONE);
    disable_ack = (state_q == ABORT);
    count       = count_q;
    aborted     = aborted_q;
  end

endmodule
